// File: rtl/demux8_deser.sv
// 1:8 serial-to-byte deserializer: a 3-bit index steers each accepted bit into a
// shadow byte, and completed bytes are presented on a valid/ready output.
module demux8_deser #(
    parameter int MSB_FIRST = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [2:0] idx,
    output logic       busy
);

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] COLLECT = 2'b01;
    localparam logic [1:0] HOLD    = 2'b10;

    logic [1:0] state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shadow_q, shadow_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;

    logic       accept;
    logic [2:0] pos;
    logic [7:0] merged;

    // While a byte is held, input flow is gated by the consumer so no bit is lost.
    assign in_ready  = (state_q == HOLD) ? out_ready : 1'b1;
    assign accept    = in_valid && in_ready;
    assign pos       = (MSB_FIRST != 0) ? (3'd7 - idx_q) : idx_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign idx       = idx_q;
    assign busy      = (state_q != IDLE);

    always_comb begin
        merged      = shadow_q;
        merged[pos] = in_bit;
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shadow_d = merged;
                    idx_d    = 3'd1;
                    state_d  = COLLECT;
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (idx_q == 3'd7) begin
                        out_data_d  = merged;
                        out_valid_d = 1'b1;
                        shadow_d    = 8'h00;
                        idx_d       = 3'd0;
                        state_d     = HOLD;
                    end else begin
                        shadow_d = merged;
                        idx_d    = idx_q + 3'd1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (in_valid) begin
                        // Back-to-back frame: idx is already 0 and shadow already cleared.
                        shadow_d = merged;
                        idx_d    = 3'd1;
                        state_d  = COLLECT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                idx_d       = 3'd0;
                shadow_d    = 8'h00;
                out_valid_d = 1'b0;
            end
        endcase

        // Abort wins over any accept or handshake in the same cycle; out_data is kept.
        if (clear) begin
            state_d     = IDLE;
            idx_d       = 3'd0;
            shadow_d    = 8'h00;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            shadow_q    <= 8'h00;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_demux8_deser.sv
// Directed bench for demux8_deser: LSB-first and MSB-first instances share one
// stimulus stream; expected values are hand-computed constants.
module tb_demux8_deser;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic       in_bit;
    logic       out_ready;
    logic       in_ready0, in_ready1;
    logic       out_valid0, out_valid1;
    logic [7:0] out_data0, out_data1;
    logic [2:0] idx0, idx1;
    logic       busy0, busy1;

    int n_cmp  = 0;
    int n_fail = 0;

    demux8_deser #(.MSB_FIRST(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready0),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .out_data  (out_data0),
        .idx       (idx0),
        .busy      (busy0)
    );

    demux8_deser #(.MSB_FIRST(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready1),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_data  (out_data1),
        .idx       (idx1),
        .busy      (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Present one input cycle, then return 1 time unit after the capturing edge.
    task automatic step(input logic v, input logic b);
        in_valid = v;
        in_bit   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte_lsb(input logic [7:0] value);
        for (int i = 0; i < 8; i++) step(1'b1, value[i]);
    endtask

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {7'd0, out_valid0}, 8'h00);
        check("rst_out_data",  out_data0, 8'h00);
        check("rst_idx",       {5'd0, idx0}, 8'h00);
        check("rst_busy",      {7'd0, busy0}, 8'h00);
        rst = 1'b0;
        #1;
        check("rst_in_ready",  {7'd0, in_ready0}, 8'h01);

        // Stream 1,0,1,1,0,0,1,0 on consecutive cycles
        @(posedge clk);
        #1;
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("t1_idx_mid",  {5'd0, idx0}, 8'h03);
        check("t1_busy_mid", {7'd0, busy0}, 8'h01);
        check("t1_ov_mid",   {7'd0, out_valid0}, 8'h00);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        check("t1_out_valid", {7'd0, out_valid0}, 8'h01);
        check("t1_lsb_data",  out_data0, 8'h4D);
        check("t1_msb_data",  out_data1, 8'hB2);
        check("t1_idx_wrap",  {5'd0, idx0}, 8'h00);
        step(1'b0, 1'b0);
        check("t1_ov_pulse",  {7'd0, out_valid0}, 8'h00);
        check("t1_busy_idle", {7'd0, busy0}, 8'h00);
        check("t1_data_keep", out_data0, 8'h4D);

        // 0x5A with the consumer stalled for 5 cycles
        out_ready = 1'b0;
        send_byte_lsb(8'h5A);
        check("t3_out_valid", {7'd0, out_valid0}, 8'h01);
        check("t3_data",      out_data0, 8'h5A);
        check("t3_in_ready",  {7'd0, in_ready0}, 8'h00);
        repeat (5) step(1'b1, 1'b1);
        check("t3_hold_valid", {7'd0, out_valid0}, 8'h01);
        check("t3_hold_data",  out_data0, 8'h5A);
        check("t3_hold_idx",   {5'd0, idx0}, 8'h00);
        check("t3_hold_ready", {7'd0, in_ready0}, 8'h00);
        out_ready = 1'b1;
        step(1'b0, 1'b0);
        check("t3_release_valid", {7'd0, out_valid0}, 8'h00);
        check("t3_release_idx",   {5'd0, idx0}, 8'h00);
        check("t3_release_busy",  {7'd0, busy0}, 8'h00);

        // Back-to-back 0xFF then 0x01, in_valid continuous
        send_byte_lsb(8'hFF);
        check("t4_first_valid", {7'd0, out_valid0}, 8'h01);
        check("t4_first_data",  out_data0, 8'hFF);
        step(1'b1, 1'b1);
        check("t4_no_bubble_valid", {7'd0, out_valid0}, 8'h00);
        check("t4_no_bubble_idx",   {5'd0, idx0}, 8'h01);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
        check("t4_second_valid", {7'd0, out_valid0}, 8'h01);
        check("t4_second_data",  out_data0, 8'h01);
        step(1'b0, 1'b0);
        check("t4_end_valid", {7'd0, out_valid0}, 8'h00);

        // Five bits, clear with in_valid high, then 0x3C
        repeat (5) step(1'b1, 1'b1);
        check("t5_idx_pre", {5'd0, idx0}, 8'h05);
        clear = 1'b1;
        step(1'b1, 1'b1);
        clear = 1'b0;
        check("t5_idx_clear",  {5'd0, idx0}, 8'h00);
        check("t5_busy_clear", {7'd0, busy0}, 8'h00);
        check("t5_ov_clear",   {7'd0, out_valid0}, 8'h00);
        check("t5_data_keep",  out_data0, 8'h01);
        send_byte_lsb(8'h3C);
        check("t5_valid", {7'd0, out_valid0}, 8'h01);
        check("t5_data",  out_data0, 8'h3C);

        // clear while holding drops the byte but keeps out_data
        out_ready = 1'b0;
        clear     = 1'b1;
        step(1'b0, 1'b0);
        clear     = 1'b0;
        out_ready = 1'b1;
        check("t5_hold_clear_valid", {7'd0, out_valid0}, 8'h00);
        check("t5_hold_clear_busy",  {7'd0, busy0}, 8'h00);
        check("t5_hold_clear_data",  out_data0, 8'h3C);

        // Asynchronous reset mid-frame at idx=4, then 0x81
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        check("t6_idx_pre", {5'd0, idx0}, 8'h04);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_idx",   {5'd0, idx0}, 8'h00);
        check("t6_async_busy",  {7'd0, busy0}, 8'h00);
        check("t6_async_valid", {7'd0, out_valid0}, 8'h00);
        check("t6_async_data",  out_data0, 8'h00);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_byte_lsb(8'h81);
        check("t6_valid",    {7'd0, out_valid0}, 8'h01);
        check("t6_data",     out_data0, 8'h81);
        check("t6_msb_data", out_data1, 8'h81);
        step(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
